regf_multi_port: RTL and testbench
==================================

REGF_MULTI_PORT -- requirements
Module: regf_multi_port

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter RD_PORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port we, input, 1, write enable.
REQ-007 SHALL have port waddr, input, ADDR_W, write address.
REQ-008 SHALL have port wdata, input, DATA_W, write data.
REQ-009 SHALL have port wbe, input, DATA_W/8, byte write enables; present only with REGF_BYTE_WE_EN.
REQ-010 SHALL have port re, input, RD_PORTS, per-port read enable.
REQ-011 SHALL have port raddr, input, RD_PORTS*ADDR_W, read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rdata, output, RD_PORTS*DATA_W, read data; port p occupies bits [p*DATA_W +: DATA_W].
REQ-013 SHALL have port init_busy, output, 1, high while the clear sequence runs.

Function
REQ-014 SHALL return read data one cycle after re[p]=1 sampled high (latency 1).
REQ-015 SHALL hold rdata of port p unchanged in cycles following re[p]=0.
REQ-016 SHALL forward: we=1, re[p]=1, waddr==raddr[p] in the same cycle -> rdata[p] next cycle equals the newly written word (write-first), for every port independently.
REQ-017 SHALL, with byte enables, forward merged data: enabled bytes from wdata, other bytes from stored word.
REQ-018 SHALL make a write visible to plain (non-forwarded) reads issued from the next cycle onward.
REQ-019 SHALL implement FSM INIT/RUN; INIT writes zero to entry cnt each cycle, cnt 0..DEPTH-1, then goes to RUN.
REQ-020 SHALL keep init_busy=1 during rst and for exactly DEPTH cycles after rst deasserts; 0 in RUN.
REQ-021 SHALL ignore we during INIT (no write, no forward).
REQ-022 SHALL drive zero as read result for reads issued during INIT.
REQ-023 SHALL accept reads to any address including DEPTH-1; cnt SHALL not wrap past DEPTH-1 (INIT runs once per reset).

Reset
REQ-024 SHALL on rst=1 set rdata all-zero, FSM to INIT, cnt to 0, init_busy to 1, asynchronously.
REQ-025 SHALL restart clear from entry 0 when rst asserts mid-INIT or mid-RUN; prior contents are not guaranteed until init completes.
REQ-026 SHALL not reset storage array directly; contents zeroed only by the INIT sequence.

Configuration
REQ-027 SHALL, with macro REGF_BYTE_WE_EN defined, add port wbe and write/forward only enabled bytes; DATA_W SHALL then be a multiple of 8.
REQ-028 SHALL, without REGF_BYTE_WE_EN, omit wbe and write full words on we=1.

Structure
REQ-029 SHALL place default DATA_W/ADDR_W/RD_PORTS constants and the FSM state type (INIT, RUN) in shared package regf_pkg.
REQ-030 SHALL instantiate one sub-module regf_bank_1w1r per read port (1 write, 1 registered read, replicated write), all banks written identically.
REQ-031 SHALL keep forwarding compare, INIT FSM and output mux in regf_multi_port top.

Verification
REQ-032 SHALL cover init: release rst, read addr 5 at cycle 3 -> rdata 0; init_busy high 16 cycles, then low.
REQ-033 SHALL cover forwarding: we=1 waddr=3 wdata=0xDEADBEEF with re[0]=1 raddr0=3, re[1]=1 raddr1=3 same cycle -> both ports 0xDEADBEEF next cycle.
REQ-034 SHALL cover ordering: write 0x11111111 to 7, next cycle read 7 on port 1 -> 0x11111111; port 0 re=0 holds previous value.
REQ-035 SHALL cover byte enables (REGF_BYTE_WE_EN): entry 2=0xAABBCCDD, write 0x11223344 wbe=0b0101 with same-cycle read -> 0xAA22CC44.
REQ-036 SHALL cover rst mid-INIT: write 0x5 to 15 in RUN, assert rst at init cycle 8 -> busy restarts 16 cycles, then read 15 -> 0.
REQ-037 SHALL cover INIT write drop: we=1 waddr=0 wdata=0xFF during INIT -> entry 0 reads 0 after init.

Source files
------------

// File: rtl/regf_pkg.sv
// Shared defaults and FSM state type for the multi-port register file.
package regf_pkg;

  localparam int REGF_DATA_W   = 32;
  localparam int REGF_ADDR_W   = 4;
  localparam int REGF_RD_PORTS = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } regf_state_e;

endpackage

// File: rtl/regf_bank_1w1r.sv
// One storage bank: single bit-masked write port, single registered read port.
// Storage is deliberately not reset; the top clears it through the write port.
module regf_bank_1w1r
  import regf_pkg::*;
#(
  parameter int DATA_W = REGF_DATA_W,
  parameter int ADDR_W = REGF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_word
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents; the top layers forwarding on top.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (wdata & wmask) | (mem[waddr] & ~wmask);
    end
    if (re) begin
      rd_word <= mem[raddr];
    end
  end

endmodule

// File: rtl/regf_multi_port.sv
// Multi-read-port register file with write-first forwarding and a post-reset
// clear sequence. Define REGF_BYTE_WE_EN to add the wbe byte-enable port.
module regf_multi_port
  import regf_pkg::*;
#(
  parameter int DATA_W   = REGF_DATA_W,
  parameter int ADDR_W   = REGF_ADDR_W,
  parameter int RD_PORTS = REGF_RD_PORTS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
`ifdef REGF_BYTE_WE_EN
  input  logic [DATA_W/8-1:0]        wbe,
`endif
  input  logic [RD_PORTS-1:0]        re,
  input  logic [RD_PORTS*ADDR_W-1:0] raddr,
  output logic [RD_PORTS*DATA_W-1:0] rdata,
  output logic                       init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] nw,
                                                   input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] mask);
    return (nw & mask) | (old & ~mask);
  endfunction

  regf_state_e       state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] wr_mask;
  logic              wr_run;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_wmask;

`ifdef REGF_BYTE_WE_EN
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      wr_mask[b*8 +: 8] = {8{wbe[b]}};
    end
  end
`else
  assign wr_mask = '1;
`endif

  // Clear sequence: one entry per cycle, stops at DEPTH-1 without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          init_busy <= 1'b0;
        end
      endcase
    end
  end

  // User writes are dropped while clearing; the clear owns the write port.
  assign wr_run     = (state == RUN) && we;
  assign bank_we    = (state == INIT) || we;
  assign bank_waddr = (state == INIT) ? cnt : waddr;
  assign bank_wdata = (state == INIT) ? '0  : wdata;
  assign bank_wmask = (state == INIT) ? '1  : wr_mask;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] raddr_p0;
    logic [DATA_W-1:0] rd_word_p1;
    logic [DATA_W-1:0] fwd_data_p1;
    logic [DATA_W-1:0] fwd_mask_p1;
    logic              zero_p1;
    logic              fwd_p1;

    assign raddr_p0 = raddr[p*ADDR_W +: ADDR_W];

    regf_bank_1w1r #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .we      (bank_we),
      .waddr   (bank_waddr),
      .wdata   (bank_wdata),
      .wmask   (bank_wmask),
      .re      (re[p]),
      .raddr   (raddr_p0),
      .rd_word (rd_word_p1)
    );

    // p0 -> p1: capture read qualifiers; all hold while re[p] is low.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        zero_p1 <= 1'b1;
        fwd_p1  <= 1'b0;
      end else if (re[p]) begin
        zero_p1 <= (state == INIT);
        fwd_p1  <= wr_run && (waddr == raddr_p0);
      end
    end

    always_ff @(posedge clk) begin
      if (re[p]) begin
        fwd_data_p1 <= wdata;
        fwd_mask_p1 <= wr_mask;
      end
    end

    assign rdata[p*DATA_W +: DATA_W] =
      zero_p1 ? '0 :
      fwd_p1  ? merge_word(fwd_data_p1, rd_word_p1, fwd_mask_p1) :
                rd_word_p1;
  end

endmodule

// File: tb/tb_regf_multi_port.sv
// Scoreboard bench for regf_multi_port: a cycle model pushes expected outputs,
// a negedge monitor pops and compares. Honors REGF_BYTE_WE_EN.
module tb_regf_multi_port;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int RD_PORTS = 2;
  localparam int DEPTH    = 16;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
`ifdef REGF_BYTE_WE_EN
  logic [DATA_W/8-1:0]        wbe;
  logic [DATA_W/8-1:0]        wbe_sel;
`endif
  logic [RD_PORTS-1:0]        re;
  logic [RD_PORTS*ADDR_W-1:0] raddr;
  logic [RD_PORTS*DATA_W-1:0] rdata;
  logic                       init_busy;

  regf_multi_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RD_PORTS (RD_PORTS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
`ifdef REGF_BYTE_WE_EN
    .wbe       (wbe),
`endif
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RD_PORTS*DATA_W-1:0] rd;
    logic                       busy;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_n  = 0;

  // Reference model: contents as an array, clear modelled as a countdown.
  logic [DATA_W-1:0] mdl_mem  [DEPTH];
  logic [DATA_W-1:0] mdl_held [RD_PORTS];
  int                init_left = DEPTH;

  always @(posedge clk) begin : model
    exp_t              e;
    logic [DATA_W-1:0] wr_word;
    logic [ADDR_W-1:0] a;
    if (rst) begin
      init_left = DEPTH;
      for (int p = 0; p < RD_PORTS; p++) mdl_held[p] = '0;
    end else begin
`ifdef REGF_BYTE_WE_EN
      wr_word = mdl_mem[waddr];
      for (int b = 0; b < DATA_W / 8; b++)
        if (wbe[b]) wr_word[b*8 +: 8] = wdata[b*8 +: 8];
`else
      wr_word = wdata;
`endif
      for (int p = 0; p < RD_PORTS; p++) begin
        if (re[p]) begin
          a = raddr[p*ADDR_W +: ADDR_W];
          if (init_left > 0)            mdl_held[p] = '0;
          else if (we && waddr == a)    mdl_held[p] = wr_word;
          else                          mdl_held[p] = mdl_mem[a];
        end
      end
      if (init_left > 0) begin
        init_left--;
        if (init_left == 0)
          for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      end else if (we) begin
        mdl_mem[waddr] = wr_word;
      end
    end
    for (int p = 0; p < RD_PORTS; p++) e.rd[p*DATA_W +: DATA_W] = mdl_held[p];
    e.busy = rst || (init_left > 0);
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc_n++;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty cycle %0d: no expected entry", cyc_n);
    end else begin
      e = sb.pop_front();
      for (int p = 0; p < RD_PORTS; p++) begin
        n_chk++;
        if (rdata[p*DATA_W +: DATA_W] !== e.rd[p*DATA_W +: DATA_W]) begin
          n_fail++;
          $display("FAIL rdata[%0d] cycle %0d: got %h expected %h", p, cyc_n,
                   rdata[p*DATA_W +: DATA_W], e.rd[p*DATA_W +: DATA_W]);
        end
      end
      n_chk++;
      if (init_busy !== e.busy) begin
        n_fail++;
        $display("FAIL init_busy cycle %0d: got %b expected %b", cyc_n, init_busy, e.busy);
      end
    end
  end

  task automatic drive(input logic r_rst, input logic w, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic [RD_PORTS-1:0] rr,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    @(negedge clk);
    #1;
    rst   = r_rst;
    we    = w;
    waddr = wa;
    wdata = wd;
    re    = rr;
    raddr = {a1, a0};
`ifdef REGF_BYTE_WE_EN
    wbe     = wbe_sel;
    wbe_sel = '1;
`endif
  endtask

  initial begin
    rst   = 1'b1;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    re    = '0;
    raddr = '0;
`ifdef REGF_BYTE_WE_EN
    wbe     = '1;
    wbe_sel = '1;
`endif
    repeat (3) drive(1, 0, 0, 0, 2'b00, 0, 0);

    // Clear phase: dropped write to entry 0, read of entry 5 at cycle 3.
    drive(0, 0, 0, 32'h0, 2'b00, 0, 0);
    drive(0, 1, 0, 32'hFF, 2'b00, 0, 0);
    drive(0, 0, 0, 32'h0, 2'b01, 5, 0);
    repeat (13) drive(0, 0, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b11, 0, 5);

    // Same-cycle forwarding to both ports, then write-then-read ordering.
    drive(0, 1, 3, 32'hDEADBEEF, 2'b11, 3, 3);
    drive(0, 1, 7, 32'h11111111, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b10, 0, 7);
    drive(0, 0, 0, 0, 2'b00, 0, 0);

    // Partial write with same-cycle read of the same entry.
    drive(0, 1, 2, 32'hAABBCCDD, 2'b00, 0, 0);
`ifdef REGF_BYTE_WE_EN
    wbe_sel = 4'b0101;
`endif
    drive(0, 1, 2, 32'h11223344, 2'b11, 2, 2);
    drive(0, 0, 0, 0, 2'b11, 2, 2);
    drive(0, 0, 0, 0, 2'b11, 15, 3);

    // Reset during RUN, then again 8 cycles into the clear.
    drive(0, 1, 15, 32'h5, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b10, 0, 15);
    drive(1, 0, 0, 0, 2'b00, 0, 0);
    repeat (8) drive(0, 0, 0, 0, 2'b00, 0, 0);
    drive(1, 0, 0, 0, 2'b00, 0, 0);
    repeat (16) drive(0, 0, 0, 0, 2'b00, 0, 0);
    drive(0, 0, 0, 0, 2'b11, 15, 15);
    drive(0, 0, 0, 0, 2'b00, 0, 0);

    // Randomised traffic on a narrow address window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] wa, a0, a1;
      wa = (i % 3 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 3));
      a0 = ($urandom_range(0, 3) == 0) ? ADDR_W'(DEPTH - 1) : ADDR_W'($urandom_range(0, 3));
      a1 = ADDR_W'($urandom_range(0, 3));
`ifdef REGF_BYTE_WE_EN
      wbe_sel = 4'($urandom);
`endif
      drive((i == 200) ? 1'b1 : 1'b0, 1'($urandom), wa, DATA_W'($urandom),
            RD_PORTS'($urandom), a0, a1);
    end

    drive(0, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
